// File: rtl/sprite_draw_scheduler.sv
// Round-robin scheduler that rasters one sprite rectangle at a time onto the shared VGA write port.
// Pixels leave a 2-stage pipeline aligned with the 1-cycle sprite ROM; offscreen pixels are clipped.
module sprite_draw_scheduler #(
  parameter logic [7:0] X_SCREEN_PIXELS = 8'd160,
  parameter logic [6:0] Y_SCREEN_PIXELS = 7'd120
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [2:0]  clr,
  input  logic [23:0] x0_bus,
  input  logic [20:0] y0_bus,
  input  logic [11:0] w_bus,
  input  logic [11:0] h_bus,
  output logic [7:0]  rom_addr,
  input  logic [2:0]  rom_q,
  output logic [2:0]  grant,
  output logic [2:0]  done,
  output logic        busy,
  output logic [7:0]  xout,
  output logic [6:0]  yout,
  output logic [2:0]  colourOut,
  output logic        drawEn
);

  typedef enum logic [2:0] {IDLE, SCAN, FLUSH1, FLUSH2, DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  rp_q, rp_d, gidx_q, gidx_d;
  logic [2:0]  grant_q, grant_d;
  logic [7:0]  x0_q, x0_d;
  logic [6:0]  y0_q, y0_d;
  logic [3:0]  w_q, w_d, h_q, h_d, col_q, col_d, row_q, row_d;
  logic        clr_q, clr_d;
  logic [7:0]  addr_q, addr_d;
  logic        a_vld_q, a_vld_d, a_clip_q, a_clip_d;
  logic [7:0]  ax_q, ax_d;
  logic [6:0]  ay_q, ay_d;
  logic [7:0]  xout_q, xout_d;
  logic [6:0]  yout_q, yout_d;
  logic [2:0]  colour_q, colour_d;
  logic        draw_q, draw_d;
  logic        sel_vld;
  logic [1:0]  sel_idx;
  logic [8:0]  ax_sum, ay_sum;

  function automatic logic [1:0] rr_add(input logic [1:0] base, input logic [1:0] off);
    logic [2:0] s;
    s = {1'b0, base} + {1'b0, off};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  // Scan from the highest offset down so the requester nearest rp wins.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = 2'd0;
    for (int j = 2; j >= 0; j--) begin
      if (req[rr_add(rp_q, 2'(j))]) begin
        sel_vld = 1'b1;
        sel_idx = rr_add(rp_q, 2'(j));
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rp_d    = rp_q;
    gidx_d  = gidx_q;
    grant_d = grant_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    w_d     = w_q;
    h_d     = h_q;
    clr_d   = clr_q;
    col_d   = col_q;
    row_d   = row_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (sel_vld) begin
          case (sel_idx)
            2'd1: begin
              x0_d = x0_bus[15:8];  y0_d = y0_bus[13:7];  w_d = w_bus[7:4];  h_d = h_bus[7:4];
            end
            2'd2: begin
              x0_d = x0_bus[23:16]; y0_d = y0_bus[20:14]; w_d = w_bus[11:8]; h_d = h_bus[11:8];
            end
            default: begin
              x0_d = x0_bus[7:0];   y0_d = y0_bus[6:0];   w_d = w_bus[3:0];  h_d = h_bus[3:0];
            end
          endcase
          clr_d   = clr[sel_idx];
          gidx_d  = sel_idx;
          grant_d = 3'b001 << sel_idx;
          col_d   = 4'd0;
          row_d   = 4'd0;
          addr_d  = 8'd0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        // Row-major raster makes row*W+col a plain running count.
        addr_d = addr_q + 8'd1;
        if (col_q == w_q) begin
          col_d = 4'd0;
          if (row_q == h_q) state_d = FLUSH1;
          else              row_d   = row_q + 4'd1;
        end else begin
          col_d = col_q + 4'd1;
        end
      end
      FLUSH1: state_d = FLUSH2;
      FLUSH2: state_d = DONE;
      DONE: begin
        grant_d = 3'b000;
        rp_d    = rr_add(gidx_q, 2'd1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sums are 9 bits wide so an offscreen origin plus offset cannot wrap back onscreen.
  always_comb begin
    ax_sum   = {1'b0, x0_q} + {5'b0, col_q};
    ay_sum   = {2'b0, y0_q} + {5'b0, row_q};
    a_vld_d  = (state_q == SCAN);
    a_clip_d = (ax_sum >= {1'b0, X_SCREEN_PIXELS}) || (ay_sum >= {2'b0, Y_SCREEN_PIXELS});
    ax_d     = ax_sum[7:0];
    ay_d     = ay_sum[6:0];
    draw_d   = a_vld_q && !a_clip_q;
    xout_d   = xout_q;
    yout_d   = yout_q;
    colour_d = colour_q;
    if (draw_d) begin
      xout_d   = ax_q;
      yout_d   = ay_q;
      colour_d = clr_q ? 3'b000 : rom_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rp_q     <= 2'd0;
      gidx_q   <= 2'd0;
      grant_q  <= 3'b000;
      x0_q     <= 8'd0;
      y0_q     <= 7'd0;
      w_q      <= 4'd0;
      h_q      <= 4'd0;
      clr_q    <= 1'b0;
      col_q    <= 4'd0;
      row_q    <= 4'd0;
      addr_q   <= 8'd0;
      a_vld_q  <= 1'b0;
      a_clip_q <= 1'b0;
      ax_q     <= 8'd0;
      ay_q     <= 7'd0;
      xout_q   <= 8'd0;
      yout_q   <= 7'd0;
      colour_q <= 3'b000;
      draw_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rp_q     <= rp_d;
      gidx_q   <= gidx_d;
      grant_q  <= grant_d;
      x0_q     <= x0_d;
      y0_q     <= y0_d;
      w_q      <= w_d;
      h_q      <= h_d;
      clr_q    <= clr_d;
      col_q    <= col_d;
      row_q    <= row_d;
      addr_q   <= addr_d;
      a_vld_q  <= a_vld_d;
      a_clip_q <= a_clip_d;
      ax_q     <= ax_d;
      ay_q     <= ay_d;
      xout_q   <= xout_d;
      yout_q   <= yout_d;
      colour_q <= colour_d;
      draw_q   <= draw_d;
    end
  end

  assign rom_addr  = addr_q;
  assign grant     = grant_q;
  assign done      = (state_q == DONE) ? grant_q : 3'b000;
  assign busy      = (state_q != IDLE);
  assign xout      = xout_q;
  assign yout      = yout_q;
  assign colourOut = colour_q;
  assign drawEn    = draw_q;

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Directed jobs against a rectangle/round-robin model; one negedge checker compares every cycle.
module tb_sprite_draw_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [2:0]  req;
  logic [2:0]  jclr;
  logic [7:0]  jx [3];
  logic [6:0]  jy [3];
  logic [3:0]  jw [3];
  logic [3:0]  jh [3];
  logic [23:0] x0_bus;
  logic [20:0] y0_bus;
  logic [11:0] w_bus, h_bus;
  logic [7:0]  rom_addr;
  logic [2:0]  rom_q;
  logic [2:0]  grant, done, colourOut;
  logic        busy, drawEn;
  logic [7:0]  xout;
  logic [6:0]  yout;
  logic        rom_force;

  assign x0_bus = {jx[2], jx[1], jx[0]};
  assign y0_bus = {jy[2], jy[1], jy[0]};
  assign w_bus  = {jw[2], jw[1], jw[0]};
  assign h_bus  = {jh[2], jh[1], jh[0]};

  sprite_draw_scheduler dut (
    .clk(clk), .reset(reset), .req(req), .clr(jclr),
    .x0_bus(x0_bus), .y0_bus(y0_bus), .w_bus(w_bus), .h_bus(h_bus),
    .rom_addr(rom_addr), .rom_q(rom_q), .grant(grant), .done(done), .busy(busy),
    .xout(xout), .yout(yout), .colourOut(colourOut), .drawEn(drawEn)
  );

  function automatic logic [2:0] rom_f(input int k);
    return 3'((k + (k >> 3) + 1) & 7);
  endfunction

  // Sprite ROM with one cycle of read latency; forced to all-ones for the clear-mode job.
  always @(posedge clk) rom_q <= rom_force ? 3'b111 : rom_f(int'(rom_addr));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Hand-computed expectations per finished job, in completion order.
  // Job length counts the grant cycle and the done cycle inclusively.
  localparam int NJOB = 12;
  localparam logic [2:0] EXP_G [NJOB] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100,
                                          3'b001, 3'b100, 3'b001, 3'b001, 3'b100, 3'b010};
  localparam int EXP_LEN [NJOB] = '{113, 11, 19, 7, 4, 6, 7, 6, 7, 113, 6, 4};
  localparam int EXP_N   [NJOB] = '{110, 8, 4, 4, 1, 3, 4, 3, 4, 110, 3, 1};
  localparam logic [17:0] EXP_FIRST [NJOB] = '{
    {8'd73, 7'd105, 3'd1}, {8'd10, 7'd20, 3'd0}, {8'd158, 7'd118, 3'd1}, {8'd0, 7'd0, 3'd1},
    {8'd20, 7'd30, 3'd1},  {8'd100, 7'd50, 3'd1}, {8'd0, 7'd0, 3'd1}, {8'd100, 7'd50, 3'd1},
    {8'd0, 7'd0, 3'd1},    {8'd73, 7'd105, 3'd1}, {8'd100, 7'd50, 3'd1}, {8'd20, 7'd30, 3'd1}};
  localparam logic [17:0] EXP_LAST [NJOB] = '{
    {8'd83, 7'd114, 3'd3}, {8'd13, 7'd21, 3'd0}, {8'd159, 7'd119, 3'd6}, {8'd1, 7'd1, 3'd4},
    {8'd20, 7'd30, 3'd1},  {8'd102, 7'd50, 3'd3}, {8'd1, 7'd1, 3'd4}, {8'd102, 7'd50, 3'd3},
    {8'd1, 7'd1, 3'd4},    {8'd83, 7'd114, 3'd3}, {8'd102, 7'd50, 3'd3}, {8'd20, 7'd30, 3'd1}};

  int checks = 0;
  int fails  = 0;

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  logic [17:0] expq [$];
  logic [17:0] w_exp, last_w = '0, dut_first = '0, dut_last = '0;
  logic [2:0]  pred_g = '0, job_g = '0;
  bit          pend = 0, job_act = 0, chk_rst = 0, exp_idle = 0;
  int          grant_cyc = 0, job_len_m = 0, dn = 0, wr_n = 0, rp_m = 0, pi = 0;
  int          tmo_cnt = 0, tmo_ack = 0;

  always @(negedge clk) begin
    chk(tmo_cnt == tmo_ack, "wait_bound", tmo_cnt, tmo_ack);
    tmo_ack = tmo_cnt;
    if (chk_rst) begin
      chk({drawEn, grant, done, busy} == 8'd0, "reset_ctrl", {drawEn, grant, done, busy}, 0);
      chk({xout, yout, colourOut} == 18'd0, "reset_pix", {xout, yout, colourOut}, 0);
      chk(rom_addr == 8'd0, "reset_addr", rom_addr, 0);
      chk_rst = 0;
    end else begin
      if (pend) begin
        chk(grant == pred_g, "grant", grant, pred_g);
        job_g = pred_g; job_act = 1; grant_cyc = cyc; wr_n = 0; pend = 0;
      end else if (job_act) begin
        chk(grant == job_g, "grant_hold", grant, job_g);
      end
      if (drawEn) begin
        chk(expq.size() != 0, "extra_write", {xout, yout, colourOut}, 0);
        if (expq.size() != 0) begin
          w_exp = expq.pop_front();
          chk({xout, yout, colourOut} == w_exp, "pixel", {xout, yout, colourOut}, w_exp);
          last_w = w_exp;
        end
        if (wr_n == 0) dut_first = {xout, yout, colourOut};
        dut_last = {xout, yout, colourOut};
        wr_n++;
      end else begin
        chk({xout, yout, colourOut} == last_w, "hold", {xout, yout, colourOut}, last_w);
      end
      if (done != 3'b000) begin
        chk(job_act && done == job_g, "done_id", done, job_g);
        chk(cyc - grant_cyc + 1 == job_len_m, "job_len_model", cyc - grant_cyc + 1, job_len_m);
        chk(expq.size() == 0, "missing_writes", expq.size(), 0);
        chk(dn < NJOB, "extra_done", dn, NJOB);
        if (dn < NJOB) begin
          chk(done == EXP_G[dn], "order", done, EXP_G[dn]);
          chk(cyc - grant_cyc + 1 == EXP_LEN[dn], "job_len", cyc - grant_cyc + 1, EXP_LEN[dn]);
          chk(wr_n == EXP_N[dn], "write_count", wr_n, EXP_N[dn]);
          chk(dut_first == EXP_FIRST[dn], "first_write", dut_first, EXP_FIRST[dn]);
          chk(dut_last == EXP_LAST[dn], "last_write", dut_last, EXP_LAST[dn]);
        end
        dn++;
        job_act = 0;
        rp_m = job_g[1] ? 2 : (job_g[2] ? 0 : 1);
        exp_idle = 1;
      end else if (exp_idle) begin
        chk({grant, busy} == 4'd0, "idle_gap", {grant, busy}, 0);
        exp_idle = 0;
      end
      if (!busy) chk(!drawEn, "idle_draw", drawEn, 0);
      if (!busy && !reset && req != 3'b000) begin
        pred_g = 3'b000;
        for (int j = 0; j < 3; j++)
          if (pred_g == 3'b000 && req[(rp_m + j) % 3]) begin
            pi = (rp_m + j) % 3;
            pred_g = 3'(1 << pi);
          end
        pend = 1;
        job_len_m = (int'(jw[pi]) + 1) * (int'(jh[pi]) + 1) + 3;
        for (int r = 0; r <= int'(jh[pi]); r++)
          for (int c = 0; c <= int'(jw[pi]); c++)
            if (int'(jx[pi]) + c < 160 && int'(jy[pi]) + r < 120)
              expq.push_back({8'(int'(jx[pi]) + c), 7'(int'(jy[pi]) + r),
                              jclr[pi] ? 3'b000 : rom_f(r * (int'(jw[pi]) + 1) + c)});
      end
    end
    if (reset) begin
      expq.delete();
      pend = 0; job_act = 0; exp_idle = 0; rp_m = 0; last_w = '0; chk_rst = 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while ((req != 3'b000 || busy) && n < budget) begin
      tick();
      if (done != 3'b000) req = req & ~done;
      n++;
    end
    if (n >= budget) tmo_cnt++;
    tick();
  endtask

  task automatic wait_grant(input int budget);
    int n;
    n = 0;
    while (grant == 3'b000 && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) tmo_cnt++;
  endtask

  task automatic set_job(input int i, input int x, input int y, input int w, input int h);
    jx[i] = 8'(x); jy[i] = 7'(y); jw[i] = 4'(w); jh[i] = 4'(h);
  endtask

  initial begin
    reset = 1'b1; req = 3'b000; jclr = 3'b000; rom_force = 1'b0;
    for (int i = 0; i < 3; i++) set_job(i, 0, 0, 0, 0);
    repeat (3) tick();
    reset = 1'b0;
    tick();
    // Single 11x10 rocket.
    set_job(0, 73, 105, 10, 9);
    req = 3'b001;
    run_until_idle(400);
    // Clear mode, ROM output must be ignored.
    set_job(1, 10, 20, 3, 1);
    jclr = 3'b010; rom_force = 1'b1; req = 3'b010;
    run_until_idle(100);
    jclr = 3'b000; rom_force = 1'b0;
    // Clipping at the bottom-right corner.
    set_job(2, 158, 118, 3, 3);
    req = 3'b100;
    run_until_idle(100);
    // Round robin with all three requesting.
    set_job(0, 0, 0, 1, 1);
    set_job(1, 20, 30, 0, 0);
    set_job(2, 100, 50, 2, 0);
    req = 3'b111;
    run_until_idle(200);
    req = 3'b001;
    run_until_idle(100);
    req = 3'b101;
    run_until_idle(200);
    // Mid-job request changes on a rocket job.
    set_job(0, 73, 105, 10, 9);
    req = 3'b001;
    wait_grant(20);
    repeat (20) tick();
    req = 3'b100;
    run_until_idle(400);
    // Reset during pixel 5 of a rocket job.
    req = 3'b001;
    wait_grant(20);
    repeat (5) tick();
    reset = 1'b1; req = 3'b000;
    tick();
    reset = 1'b0;
    repeat (20) tick();
    req = 3'b010;
    run_until_idle(100);
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/sprite_draw_scheduler.md
Name: sprite_draw_scheduler

Overview:
- Shares the single VGA pixel-write port between three sprite requesters: 0 = rocket, 1 = alien row, 2 = bullet.
- Grants one rectangular draw or clear job at a time, using round-robin arbitration.
- For the granted job it rasters the rectangle, addresses the granted sprite ROM and aligns the ROM's 1-cycle read latency with the pixel coordinates.
- It clips pixels outside the screen and pulses a per-requester done.
- It sits between the per-object controlpaths and the VGA adapter.

Parameters:
- X_SCREEN_PIXELS, 8'd160, screen width; columns at or beyond this are clipped.
- Y_SCREEN_PIXELS, 7'd120, screen height; rows at or beyond this are clipped.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- req  in  3  per-requester job request; level, held until that requester's done.
- clr  in  3  per-requester mode: 1 = fill black (ROM ignored), 0 = draw from ROM.
- x0_bus  in  24  three 8-bit origin x values; requester i uses bits [8i+7:8i].
- y0_bus  in  21  three 7-bit origin y values; requester i uses bits [7i+6:7i].
- w_bus  in  12  three 4-bit (width-1) values; sprite width is 1..16.
- h_bus  in  12  three 4-bit (height-1) values; sprite height is 1..16.
- rom_addr  out  8  linear sprite ROM address, row*W+col.
- rom_q  in  3  colour from the granted ROM; external mux by grant; valid 1 cycle after rom_addr.
- grant  out  3  one-hot; identifies the active job.
- done  out  3  one-cycle pulse to the finished requester.
- busy  out  1  high whenever the state is not IDLE.
- xout  out  8  pixel x.
- yout  out  7  pixel y.
- colourOut  out  3  pixel colour.
- drawEn  out  1  pixel write strobe.

Behaviour:
- Reset: every output is 0, state is IDLE, round-robin pointer rp=0. Reset mid-job aborts the job with no done pulse.
- States: IDLE, SCAN, FLUSH1, FLUSH2, DONE.
- IDLE: if any req bit is high, pick the first set bit searching rp, rp+1, rp+2 (mod 3).
  - In the same cycle, latch x0, y0, W, H and clr of the selected requester.
  - grant goes high on the next edge; next state is SCAN with col=0, row=0.
- SCAN: one pixel per cycle, rom_addr=row*W+col.
  - col increments; at col=W-1 it wraps to 0 and row increments.
  - After the pixel with row=H-1 and col=W-1, go to FLUSH1. SCAN lasts exactly W*H cycles.
- Pipeline stage A (registered): pixel x = x0+col and y = y0+row, computed 9 bits wide; clip flag.
- Pipeline stage B: xout/yout take the low bits of stage A; colourOut = clr ? 3'b000 : rom_q; drawEn = valid AND NOT clip.
  - Pixel k appears on the outputs 2 cycles after its rom_addr cycle.
- Clip: x >= X_SCREEN_PIXELS or y >= Y_SCREEN_PIXELS sets drawEn=0. Coordinates never wrap onto the visible screen.
- FLUSH1, FLUSH2: drain the pipeline. FLUSH2 is the cycle in which the last pixel is visible.
- DONE: done[i]=1 for one cycle, grant returns to 0, rp=(i+1) mod 3, then go to IDLE.
  - Total job time from grant to done is W*H+3 cycles.
- req changes while granted are ignored. The latched parameters hold for the whole job, and a dropped req still completes the job.
- A requester must drop req on seeing done. If req is still high in IDLE, it is treated as a new job at the lowest round-robin priority.
- drawEn is 0 in IDLE and DONE. xout, yout and colourOut hold their last values when drawEn=0.
- The arbiter never issues back-to-back grants without passing through IDLE, so there is at least 1 idle cycle between jobs.

Test Plan:
- Single job:
  - Stimulus: reset, then req=001, clr=0, x0=73, y0=105, w=10, h=9 (11x10 rocket).
  - Response: grant=001; 110 drawEn pulses covering x 73..83, y 105..114 row-major; colourOut equals ROM word k in write k; done[0] exactly 113 cycles after grant rises.
- Clear mode:
  - Stimulus: req=010, clr=010, x0=10, y0=20, w=3, h=1 (4x2).
  - Response: 8 writes, all colourOut=000; rom_q is driven 3'b111 and is ignored.
- Clipping:
  - Stimulus: req=100, x0=158, y0=118, w=3, h=3 (4x4).
  - Response: only (158,118), (159,118), (158,119), (159,119) get drawEn; no write with x<158 or y<118; done after 19 cycles.
- Round robin:
  - Stimulus: req=111 held, each requester dropping req on its done.
  - Response: grant order 001, 010, 100. Repeat with rp=1 and req=101: order is 100 then 001.
- Mid-job events:
  - Stimulus: during the rocket job, drop req[0] and raise req[2].
  - Response: the rocket job completes all its pixels; grant=100 only after IDLE.
  - Stimulus: assert reset at pixel 5.
  - Response: drawEn=0, grant=000, busy=0 next cycle, no done pulse.
